// File: rtl/riscv_pkg.sv
// Shared constants for the instruction issue unit: legal opcodes, FSM states,
// PC step and the immediate/legality decode helpers.
package riscv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [7:0] PC_STEP  = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LUI) || (op == OP_AUIPC);
    endfunction

    // Shift-immediates expose only the shamt; funct7 carries the SRAI selector.
    function automatic logic [11:0] decode_imm(input logic [31:0] ins);
        logic [11:0] v_imm;
        v_imm = 12'd0;
        case (ins[6:0])
            OP_I: begin
                if ((ins[14:12] == 3'b001) || (ins[14:12] == 3'b101))
                    v_imm = {7'b0, ins[24:20]};
                else
                    v_imm = ins[31:20];
            end
            OP_LUI, OP_AUIPC: v_imm = ins[31:20];
            default:          v_imm = 12'd0;
        endcase
        return v_imm;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two operand read ports, one debug read port and a
// single synchronous write port; x0 always reads as zero.
module reg_file
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] dbg_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] r_regs [0:31];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (wr_en && (wr_addr != 5'd0)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : r_regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : r_regs[rs2_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : r_regs[dbg_addr];

endmodule

// File: rtl/instr_issue_unit.sv
// Single-issue RV32 decode/issue sequencer: captures one instruction, presents
// decoded fields and operands to an external ALU, and writes the result back.
module instr_issue_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [6:0]  opcode,
    output logic [6:0]  funct7,
    output logic [2:0]  funct3,
    output logic [11:0] imm,
    output logic [7:0]  PC,
    output logic [31:0] rs1_val,
    output logic [31:0] rs2_val,
    input  logic [31:0] rd_val,
    output logic        done,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    // state   | meaning
    // IDLE    | ready, waiting for instr_valid
    // DECODE  | fields decoded, operands read from reg file
    // EXEC    | ALU-facing outputs stable, rd_val sampled at exit
    // WB      | done/illegal pulse, write-back and PC step at exit

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_instr;
    logic [31:0] r_result;
    logic [7:0]  r_pc;
    logic [6:0]  r_opcode;
    logic [6:0]  r_funct7;
    logic [2:0]  r_funct3;
    logic [11:0] r_imm;
    logic [31:0] r_rs1_val;
    logic [31:0] r_rs2_val;

    logic        w_legal;
    logic        w_wr_en;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;

    assign w_legal = is_legal(r_instr[6:0]);

    reg_file u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (r_instr[19:15]),
        .rs2_addr (r_instr[24:20]),
        .dbg_addr (dbg_addr),
        .rs1_data (w_rs1_data),
        .rs2_data (w_rs2_data),
        .dbg_data (dbg_data),
        .wr_en    (w_wr_en),
        .wr_addr  (r_instr[11:7]),
        .wr_data  (r_result)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (instr_valid) w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = w_legal ? ST_EXEC : ST_WB;
            ST_EXEC:   w_next_state = ST_WB;
            ST_WB:     w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            ST_IDLE: instr_ready = 1'b1;
            ST_WB: begin
                done    = w_legal;
                illegal = !w_legal;
                w_wr_en = w_legal;
            end
            default: ;
        endcase
    end

    // Illegal opcodes never load the ALU-facing registers, so they stay zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr   <= 32'd0;
            r_result  <= 32'd0;
            r_pc      <= 8'd0;
            r_opcode  <= 7'd0;
            r_funct7  <= 7'd0;
            r_funct3  <= 3'd0;
            r_imm     <= 12'd0;
            r_rs1_val <= 32'd0;
            r_rs2_val <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) r_instr <= instr;
                end
                ST_DECODE: begin
                    if (w_legal) begin
                        r_opcode  <= r_instr[6:0];
                        r_funct7  <= r_instr[31:25];
                        r_funct3  <= r_instr[14:12];
                        r_imm     <= decode_imm(r_instr);
                        r_rs1_val <= w_rs1_data;
                        r_rs2_val <= w_rs2_data;
                    end
                end
                ST_EXEC: begin
                    r_result <= rd_val;
                end
                ST_WB: begin
                    r_pc      <= r_pc + PC_STEP;
                    r_opcode  <= 7'd0;
                    r_funct7  <= 7'd0;
                    r_funct3  <= 3'd0;
                    r_imm     <= 12'd0;
                    r_rs1_val <= 32'd0;
                    r_rs2_val <= 32'd0;
                end
                default: ;
            endcase
        end
    end

    assign opcode  = r_opcode;
    assign funct7  = r_funct7;
    assign funct3  = r_funct3;
    assign imm     = r_imm;
    assign rs1_val = r_rs1_val;
    assign rs2_val = r_rs2_val;
    assign PC      = r_pc;

endmodule

// File: doc/instr_issue_unit.md
INSTR_ISSUE_UNIT -- requirements
Module: instr_issue_unit

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: instr_valid  input  1  instruction word offered.
REQ-004 SHALL have: instr  input  32  RV32 instruction word.
REQ-005 SHALL have: instr_ready  output  1  unit can accept an instruction.
REQ-006 SHALL have: opcode  output  7; funct7  output  7; funct3  output  3; imm  output  12.
- Decoded fields driven to the ALU.
REQ-007 SHALL have: PC  output  8  address of the instruction in flight.
REQ-008 SHALL have: rs1_val  output  32; rs2_val  output  32.
- Register-file operands driven to the ALU.
REQ-009 SHALL have: rd_val  input  32  combinational ALU result.
REQ-010 SHALL have: done  output  1  one-cycle pulse at retire.
- illegal  output  1  one-cycle pulse, unsupported opcode.
REQ-011 SHALL have: dbg_addr  input  5; dbg_data  output  32.
- Asynchronous (combinational) register-file read port for the bench.

Function
REQ-012 SHALL implement FSM IDLE -> DECODE -> EXEC -> WB -> IDLE.
REQ-013 SHALL assert instr_ready only in IDLE.
- instr captured on the edge where instr_valid && instr_ready.
- Otherwise stays in IDLE.
REQ-014 SHALL decode in DECODE and register all ALU-facing outputs on the DECODE->EXEC edge.
- Outputs held stable through EXEC and WB.
- Outputs are zero in IDLE.
REQ-015 SHALL decode fields as follows:
- opcode = instr[6:0]
- funct3 = instr[14:12]
- funct7 = instr[31:25]
- rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7]
REQ-016 SHALL drive imm per instruction type:
- opcode 0010011 with funct3 001/101: imm = {7'b0, instr[24:20]}.
- Other 0010011: imm = instr[31:20].
- 0110111 and 0010111: imm = instr[31:20].
- 0110011: imm = 0.
REQ-017 SHALL register rd_val on the EXEC->WB edge.
REQ-018 SHALL write the captured result to register rd on the WB->IDLE edge, unless rd = 0.
REQ-019 SHALL return 0 for x0 reads; writes to x0 are discarded.
REQ-020 SHALL pulse done during WB.
- Fixed latency: accept at edge N, done high in the cycle after edge N+2, instr_ready high again after edge N+3.
REQ-021 SHALL treat only opcodes 0110011, 0010011, 0110111, 0010111 as legal.
- Any other opcode goes DECODE -> WB: no register write, illegal pulsed in WB instead of done, ALU-facing outputs stay 0.
REQ-022 SHALL increment PC by 4 on every WB->IDLE edge, legal or illegal, wrapping 252 -> 0 (8-bit modulo).
REQ-023 SHALL read rs1/rs2 in DECODE, after any write completed by the preceding WB.
- Back-to-back dependent instructions therefore see the updated value; no hazard logic is needed.
REQ-024 SHALL ignore instr_valid outside IDLE; instr changes outside IDLE have no effect.

Reset
REQ-025 SHALL, while rst = 0 at a rising edge:
- force state IDLE and PC = 0
- zero all ALU-facing outputs, done, illegal, and all 32 registers
- abandon any in-flight instruction without writeback.
REQ-026 SHALL drive instr_ready = 1 in the first cycle after rst returns to 1.

Structure
REQ-027 SHALL place opcode constants (OP_R, OP_I, OP_LUI, OP_AUIPC), FSM state encodings and the PC step of 4 in shared package riscv_pkg.
REQ-028 SHALL instantiate one sub-module reg_file:
- 32x32 registers
- two combinational read ports plus the dbg port
- one synchronous write port, x0 hardwired to 0.

Verification
REQ-029 ADD x3,x1,x2 with x1 = 5, x2 = 7 (preloaded via ADDI):
- opcode 0110011, funct7 0, funct3 0 at EXEC
- x3 = 12, done 3 cycles after accept, PC advanced by 4.
REQ-030 SRAI x5,x4,4 with x4 = 0xFFFFFF00:
- imm = 0x004, funct7 = 0100000 presented to the ALU
- dbg_data(x5) equals the ALU rd_val.
REQ-031 ADDI x0,x0,100, then dbg_addr = 0 -> dbg_data = 0, done pulses.
REQ-032 Instruction 0x00000073 (opcode 1110011):
- illegal pulses, no done, register file unchanged, PC +4.
REQ-033 64 consecutive legal instructions from reset:
- PC sequence 0,4,...,252,0.
- instr_valid held high proves one accept per 4 cycles.
REQ-034 rst = 0 asserted during EXEC of ADDI x6,x0,9:
- x6 stays 0, PC = 0, instr_ready = 1 the cycle after rst releases.
